// File: rtl/bip_alu_pkg.sv
// bip_alu_pkg: shared definitions for the sequential BIP ALU.
//   - opcode encodings (OP_SUB..OP_MUL)
//   - control state encoding (ST_IDLE, ST_MUL)
//   - bit indices into the registered flag vector
package bip_alu_pkg;

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_NUM   = 4;

endpackage

// File: rtl/bip_alu_mul.sv
// bip_alu_mul: iterative unsigned shift-add multiplier, one multiplier bit
// per clock, DATA_W clocks per product.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (aborts a product)
//   start       : latch a/b and begin; ignored by design while busy is
//                 guaranteed by the caller
//   a, b        : operands
//   done        : high during the final iteration cycle
//   product     : full 2*DATA_W product, valid while done is high
module bip_alu_mul #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int SH_W = $clog2(DATA_W);

  logic                busy;
  logic [SH_W-1:0]     cnt;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] acc;

  // product is the accumulator after this cycle's partial product, so the
  // caller can register the final value on the same edge that ends busy.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == SH_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{DATA_W{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/bip_alu_seq.sv
// bip_alu_seq: sequential BIP ALU with valid/ready request handshake and a
// registered result plus zero/negative/carry/overflow flags.
// Build option: define BIP_ALU_MUL_EN to build the iterative multiplier for
// opcode 111; otherwise opcode 111 returns 0 in one cycle.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_valid, o_ready  : request handshake, accept = i_valid && o_ready
//   i_op, i_a, i_b    : opcode and operands, sampled at accept
//   o_valid           : one-cycle result pulse (no backpressure)
//   o_result          : result, held until the next completion
//   o_zero, o_neg, o_carry, o_ovf : status flags for o_result
module bip_alu_seq
  import bip_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  localparam int SH_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_neg,
  output logic              o_carry,
  output logic              o_ovf
);

  localparam int MSB = DATA_W - 1;

  logic accept;
  assign accept = i_valid && o_ready;

  // ---- single-cycle datapath ----
  logic [DATA_W:0]   sum_ext, dif_ext;
  logic [SH_W-1:0]   sh;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v;

  assign sum_ext = {1'b0, i_a} + {1'b0, i_b};
  assign dif_ext = {1'b0, i_a} - {1'b0, i_b};
  assign sh      = i_b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (i_op)
      OP_SUB: begin
        alu_res = dif_ext[MSB:0];
        alu_c   = ~dif_ext[DATA_W];  // no borrow: A >= B
        alu_v   = (i_a[MSB] ^ i_b[MSB]) & (dif_ext[MSB] ^ i_a[MSB]);
      end
      OP_ADD: begin
        alu_res = sum_ext[MSB:0];
        alu_c   = sum_ext[DATA_W];
        alu_v   = ~(i_a[MSB] ^ i_b[MSB]) & (sum_ext[MSB] ^ i_a[MSB]);
      end
      OP_AND:  alu_res = i_a & i_b;
      OP_OR:   alu_res = i_a | i_b;
      OP_XOR:  alu_res = i_a ^ i_b;
      OP_SRL:  alu_res = i_a >> sh;
      OP_SRA:  alu_res = $unsigned($signed(i_a) >>> sh);
      default: alu_res = '0;  // OP_MUL without multiplier: zero result
    endcase
  end

  // ---- completion source select ----
  logic              ld;
  logic [DATA_W-1:0] ld_res;
  logic              ld_c, ld_v;

`ifdef BIP_ALU_MUL_EN
  logic                mul_start, mul_done;
  logic [2*DATA_W-1:0] mul_prod;
  state_t              state_q, state_d;

  assign mul_start = accept && (i_op == OP_MUL);

  bip_alu_mul #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (i_a),
    .b       (i_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_ready = (state_q == ST_IDLE);

  // accept and mul_done never coincide: o_ready is low while multiplying
  always_comb begin
    ld     = (accept && !mul_start) || mul_done;
    ld_res = mul_done ? mul_prod[MSB:0] : alu_res;
    ld_c   = mul_done ? 1'b0 : alu_c;
    ld_v   = mul_done ? (|mul_prod[2*DATA_W-1:DATA_W]) : alu_v;
  end
`else
  assign o_ready = 1'b1;

  always_comb begin
    ld     = accept;
    ld_res = alu_res;
    ld_c   = alu_c;
    ld_v   = alu_v;
  end
`endif

  // ---- output registers ----
  logic [FLG_NUM-1:0] flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      flags_q  <= '0;
    end else begin
      o_valid <= ld;
      if (ld) begin
        o_result           <= ld_res;
        flags_q[FLG_ZERO]  <= (ld_res == '0);
        flags_q[FLG_NEG]   <= ld_res[MSB];
        flags_q[FLG_CARRY] <= ld_c;
        flags_q[FLG_OVF]   <= ld_v;
      end
    end
  end

  assign o_zero  = flags_q[FLG_ZERO];
  assign o_neg   = flags_q[FLG_NEG];
  assign o_carry = flags_q[FLG_CARRY];
  assign o_ovf   = flags_q[FLG_OVF];

endmodule

// File: tb/tb_bip_alu_seq.sv
// tb_bip_alu_seq: self-checking bench for bip_alu_seq (DATA_W=16).
// Observations are packed as {o_valid, o_result, zero, neg, carry, ovf} and
// compared against a plain-arithmetic reference model.
module tb_bip_alu_seq;

  localparam int W = 16;
  localparam longint MOD  = 64'd1 << W;
  localparam longint HALF = 64'd1 << (W - 1);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [2:0]   i_op = '0;
  logic [W-1:0] i_a = '0, i_b = '0;
  logic         o_valid;
  logic [W-1:0] o_result;
  logic         o_zero, o_neg, o_carry, o_ovf;

  int vectors = 0;
  int errors  = 0;

  bip_alu_seq #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid),
    .o_result(o_result), .o_zero(o_zero), .o_neg(o_neg),
    .o_carry(o_carry), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W+4:0] obs();
    return {o_valid, o_result, o_zero, o_neg, o_carry, o_ovf};
  endfunction

  // Reference model from the opcode rules, using wide signed integers.
  function automatic logic [W+4:0] model(int op, longint a, longint b);
    longint r, sa, sb, s, p;
    bit c, v;
    int sh;
    c = 0; v = 0; r = 0;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    sh = int'(b % W);
    case (op)
      0: begin r = (a - b + MOD) % MOD; c = (a >= b); s = sa - sb;
               v = (s >= HALF) || (s < -HALF); end
      1: begin r = (a + b) % MOD; c = (a + b >= MOD); s = sa + sb;
               v = (s >= HALF) || (s < -HALF); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a >> sh;
      6: begin s = sa >>> sh; r = (s + MOD) % MOD; end
      default: begin
`ifdef BIP_ALU_MUL_EN
        p = a * b; r = p % MOD; v = (p >= MOD);
`else
        p = 0; r = 0;
`endif
      end
    endcase
    return {1'b1, r[W-1:0], (r == 0), r[W-1], c, v};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(int op, logic [W-1:0] a, logic [W-1:0] b);
    i_valid = 1'b1; i_op = op[2:0]; i_a = a; i_b = b;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    vectors++;
    if ({obs(), o_ready} !== {{(W+5){1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL reset: got %h ready=%b, want 0 ready=1", obs(), o_ready);
    end
  endtask

  task automatic test_directed();
    logic [W+4:0] e;
    // ADD 0x7FFF+1: neg, ovf, no carry
    drive(1, 16'h7FFF, 16'h0001); tick(); i_valid = 1'b0;
    e = {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}; vectors++;
    if (obs() !== e || e !== model(1, 'h7FFF, 1)) begin
      errors++; $display("FAIL add_ovf: got %h want %h", obs(), e);
    end
    // SUB 5-5 then back-to-back SUB 3-5
    drive(0, 5, 5); tick();
    drive(0, 3, 5);
    e = {1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}; vectors++;
    if (obs() !== e) begin errors++; $display("FAIL sub_zero: got %h want %h", obs(), e); end
    tick(); i_valid = 1'b0;
    e = {1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0}; vectors++;
    if (obs() !== e) begin errors++; $display("FAIL sub_borrow: got %h want %h", obs(), e); end
    // SRA / SRL with upper shift bits set
    drive(6, 16'h8000, 16'h0014); tick();
    drive(5, 16'h8000, 16'h0014);
    e = {1'b1, 16'hF800, 1'b0, 1'b1, 1'b0, 1'b0}; vectors++;
    if (obs() !== e) begin errors++; $display("FAIL sra: got %h want %h", obs(), e); end
    tick(); i_valid = 1'b0;
    e = {1'b1, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0}; vectors++;
    if (obs() !== e) begin errors++; $display("FAIL srl: got %h want %h", obs(), e); end
    tick();
    vectors++;
    if (o_valid !== 1'b0 || o_result !== 16'h0800) begin
      errors++; $display("FAIL idle_hold: got v=%b r=%h want v=0 r=0800", o_valid, o_result);
    end
  endtask

  task automatic test_random_b2b();
    logic [W+4:0] e;
    int op, hi;
    logic [W-1:0] a, b;
`ifdef BIP_ALU_MUL_EN
    hi = 6;
`else
    hi = 7;
`endif
    e = '0;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, hi);
      a = W'($urandom); b = W'($urandom);
      if ($urandom_range(0, 5) == 0) a = 16'h8000;
      if ($urandom_range(0, 5) == 0) b = (n[0]) ? 16'hFFFF : a;
      drive(op, a, b);
      if (n > 0) begin
        vectors++;
        if (obs() !== e || o_ready !== 1'b1) begin
          errors++; $display("FAIL rand_b2b[%0d]: got %h rdy=%b want %h rdy=1", n, obs(), o_ready, e);
        end
      end
      e = model(op, longint'(a), longint'(b));
      tick();
    end
    i_valid = 1'b0;
    vectors++;
    if (obs() !== e) begin errors++; $display("FAIL rand_b2b_last: got %h want %h", obs(), e); end
    tick();
    vectors++;
    if (obs() !== {1'b0, e[W+3:0]}) begin
      errors++; $display("FAIL rand_hold: got %h want %h", obs(), {1'b0, e[W+3:0]});
    end
  endtask

`ifdef BIP_ALU_MUL_EN
  task automatic test_mul();
    logic [W+4:0] e;
    logic [W-1:0] a, b;
    int bad;
    for (int n = 0; n < 5; n++) begin
      a = (n == 0) ? 16'd300 : W'($urandom);
      b = (n == 0) ? 16'd300 : W'($urandom);
      drive(7, a, b); tick(); i_valid = 1'b0;
      bad = 0;
      for (int k = 1; k <= W; k++) begin
        if (o_ready !== 1'b0 || o_valid !== 1'b0) bad++;
        if (k == 8) drive(1, 16'd1, 16'd1);  // must be ignored
        tick(); i_valid = 1'b0;
      end
      vectors++;
      if (bad != 0) begin errors++; $display("FAIL mul_busy[%0d]: %0d bad cycles, want 0", n, bad); end
      e = model(7, longint'(a), longint'(b)); vectors++;
      if (obs() !== e || o_ready !== 1'b1) begin
        errors++; $display("FAIL mul_result[%0d]: got %h rdy=%b want %h rdy=1", n, obs(), o_ready, e);
      end
      if (n == 0) begin
        vectors++;
        if (e !== {1'b1, 16'h5F90, 1'b0, 1'b0, 1'b0, 1'b1}) begin
          errors++; $display("FAIL mul_300: got %h want 15f901", e);
        end
      end
      tick(); vectors++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL mul_extra_valid[%0d]: got 1 want 0", n); end
    end
  endtask

  task automatic test_mul_reset();
    int seen;
    drive(7, 16'd7, 16'd9); tick(); i_valid = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++;
    if ({obs(), o_ready} !== {{(W+5){1'b0}}, 1'b1}) begin
      errors++; $display("FAIL mul_reset: got %h rdy=%b want 0 rdy=1", obs(), o_ready);
    end
    seen = 0;
    for (int k = 0; k < 2 * W; k++) begin if (o_valid) seen++; tick(); end
    vectors++;
    if (seen != 0) begin errors++; $display("FAIL mul_abort: %0d o_valid pulses, want 0", seen); end
    drive(1, 16'd1, 16'd1); tick(); i_valid = 1'b0;
    vectors++;
    if (obs() !== {1'b1, 16'h0002, 4'b0000}) begin
      errors++; $display("FAIL post_reset_add: got %h want %h", obs(), {1'b1, 16'h0002, 4'b0000});
    end
  endtask
`else
  task automatic test_mul_disabled();
    drive(7, 16'd7, 16'd9);
    vectors++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL nomul_ready: got 0 want 1"); end
    tick(); i_valid = 1'b0;
    vectors++;
    if ({obs(), o_ready} !== {1'b1, 16'h0000, 4'b1000, 1'b1}) begin
      errors++; $display("FAIL nomul_result: got %h rdy=%b want %h rdy=1", obs(), o_ready, {1'b1, 16'h0000, 4'b1000});
    end
    drive(1, 16'd1, 16'd1); tick(); i_valid = 1'b0;
    vectors++;
    if (obs() !== {1'b1, 16'h0002, 4'b0000}) begin
      errors++; $display("FAIL nomul_follow_add: got %h want %h", obs(), {1'b1, 16'h0002, 4'b0000});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random_b2b();
`ifdef BIP_ALU_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    test_random_b2b();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
